// File: rtl/dispatch_nw_pkg.sv
// dispatch_nw_pkg: shared sizes, FU ids and the instruction/RS/ROB/regfile record types
package dispatch_nw_pkg;
  localparam int WIDTH = 2;
  localparam int ROB_DEPTH = 16;
  localparam int NUM_PREGS = 64;
  localparam int NUM_ALU = 2;
  localparam int NUM_CDB = 2;
  localparam int RS_SIZE = 8;
  localparam int RW = $clog2(ROB_DEPTH);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int FW = $clog2(NUM_ALU + 1);
  localparam int SW = $clog2(RS_SIZE) + 1;
  localparam logic [FW-1:0] FU_MEM = FW'(NUM_ALU);
  typedef struct packed {
    logic RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg;
    logic [3:0] ALUOp;
  } control_t;
  typedef struct packed {
    control_t control;
    logic [PW-1:0] rs1, rs2, rd;
    logic [31:0] imm;
  } dispatchStruct;
  typedef struct packed {
    logic RegWrite;
    logic [PW-1:0] addr;
    logic [31:0] data;
  } regReqStruct;
  typedef struct packed {
    logic [31:0] data;
  } regRespStruct;
  typedef struct packed {
    logic valid;
    control_t control;
    logic [PW-1:0] rd, rs1, rs2;
    logic src1rdy, src2rdy;
    logic [31:0] src1val, src2val, imm;
    logic [RW-1:0] robNum;
    logic [FW-1:0] fu;
  } rsEntry;
  typedef struct packed {
    logic valid;
    logic [RW-1:0] robNum;
    logic [PW-1:0] rd;
    logic RegWrite, MemWrite;
  } robDispatchEntry;
  function automatic logic is_mem(control_t c);
    return c.MemRead | c.MemWrite | c.MemtoReg;
  endfunction
endpackage

// File: rtl/dispatch_scoreboard.sv
// dispatch_scoreboard: physical-register ready bits; cdb set_* sets, dispatch clr_* clears (clear wins), flush/reset -> all ready, rdy[0] fixed 1
module dispatch_scoreboard
  import dispatch_nw_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic [NUM_CDB-1:0] set_valid,
  input  logic [NUM_CDB-1:0][PW-1:0] set_preg,
  input  logic [WIDTH-1:0] clr_valid,
  input  logic [WIDTH-1:0][PW-1:0] clr_preg,
  output logic [NUM_PREGS-1:0] rdy
);
  logic [NUM_PREGS-1:0] rdy_q, rdy_d;
  always_comb begin
    rdy_d = rdy_q;
    for (int c = 0; c < NUM_CDB; c++) if (set_valid[c]) rdy_d[set_preg[c]] = 1'b1;
    for (int w = 0; w < WIDTH; w++) if (clr_valid[w]) rdy_d[clr_preg[w]] = 1'b0;
    rdy_d[0] = 1'b1;
    if (flush) rdy_d = '1;
  end
  always_ff @(posedge clk) begin
    if (reset) rdy_q <= '1;
    else rdy_q <= rdy_d;
  end
  assign rdy = rdy_q;
endmodule

// File: rtl/dispatch_nw.sv
// dispatch_nw: N-wide all-or-nothing dispatch (in_valid/in_inst/in_ready, rs_free/rob_free, cdb wakeup, flush) to registered rs_line/rob_dispatch, regfile reads and phy_reg_rdy
module dispatch_nw
  import dispatch_nw_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic [WIDTH-1:0] in_valid,
  input  dispatchStruct [WIDTH-1:0] in_inst,
  output logic in_ready,
  input  logic [SW-1:0] rs_free,
  input  logic [RW:0] rob_free,
  input  logic [NUM_CDB-1:0] cdb_valid,
  input  logic [NUM_CDB-1:0][PW-1:0] cdb_preg,
  input  logic flush,
  input  logic [RW-1:0] flush_rob_ptr,
  output regReqStruct [2*WIDTH-1:0] reg_request,
  input  regRespStruct [2*WIDTH-1:0] reg_response,
  output rsEntry [WIDTH-1:0] rs_line,
  output robDispatchEntry [WIDTH-1:0] rob_dispatch,
  output logic [NUM_PREGS-1:0] phy_reg_rdy
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH:0][CW-1:0] pre, apre;
  logic [RW-1:0] rob_tail_q, rob_tail_d;
  logic [FW-1:0] rr_ptr_q, rr_ptr_d;
  logic fire;
  logic [WIDTH-1:0] clr_valid, s1, s2;
  logic [WIDTH-1:0][PW-1:0] clr_preg;
  rsEntry [WIDTH-1:0] rs_d, rs_q;
  robDispatchEntry [WIDTH-1:0] rob_d, rob_q;
  assign pre[0] = '0;
  assign apre[0] = '0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign pre[i+1] = pre[i] + CW'(in_valid[i]);
    assign apre[i+1] = apre[i] + CW'(in_valid[i] && !is_mem(in_inst[i].control));
  end
  assign fire = pre[WIDTH] != '0 && rob_free >= (RW+1)'(pre[WIDTH]) && rs_free >= SW'(pre[WIDTH]) && !flush;
  assign in_ready = fire || (pre[WIDTH] == '0 && !flush);
  always_comb begin
    rs_d = '0;
    rob_d = '0;
    reg_request = '0;
    clr_valid = '0;
    clr_preg = '0;
    s1 = '0;
    s2 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_valid[i]) begin
        reg_request[2*i].addr = in_inst[i].rs1;
        reg_request[2*i+1].addr = in_inst[i].rs2;
        s1[i] = phy_reg_rdy[in_inst[i].rs1] || in_inst[i].rs1 == '0;
        s2[i] = phy_reg_rdy[in_inst[i].rs2] || in_inst[i].rs2 == '0;
        for (int c = 0; c < NUM_CDB; c++) begin
          if (cdb_valid[c] && cdb_preg[c] == in_inst[i].rs1) s1[i] = 1'b1;
          if (cdb_valid[c] && cdb_preg[c] == in_inst[i].rs2) s2[i] = 1'b1;
        end
        for (int j = 0; j < i; j++) begin
          if (in_valid[j] && in_inst[j].control.RegWrite && in_inst[j].rd != '0) begin
            if (in_inst[j].rd == in_inst[i].rs1) s1[i] = 1'b0;
            if (in_inst[j].rd == in_inst[i].rs2) s2[i] = 1'b0;
          end
        end
        rs_d[i].valid = 1'b1;
        rs_d[i].control = in_inst[i].control;
        rs_d[i].rd = in_inst[i].rd;
        rs_d[i].rs1 = in_inst[i].rs1;
        rs_d[i].rs2 = in_inst[i].rs2;
        rs_d[i].src1rdy = s1[i];
        rs_d[i].src2rdy = s2[i] || in_inst[i].control.ALUSrc;
        rs_d[i].src1val = reg_response[2*i].data;
        rs_d[i].src2val = reg_response[2*i+1].data;
        rs_d[i].imm = in_inst[i].imm;
        rs_d[i].robNum = rob_tail_q + RW'(pre[i]);
        rs_d[i].fu = is_mem(in_inst[i].control) ? FU_MEM : FW'((int'(rr_ptr_q) + int'(apre[i])) % NUM_ALU);
        rob_d[i].valid = 1'b1;
        rob_d[i].robNum = rob_tail_q + RW'(pre[i]);
        rob_d[i].rd = in_inst[i].rd;
        rob_d[i].RegWrite = in_inst[i].control.RegWrite;
        rob_d[i].MemWrite = in_inst[i].control.MemWrite;
        clr_valid[i] = fire && in_inst[i].control.RegWrite && !in_inst[i].control.MemWrite && in_inst[i].rd != '0;
        clr_preg[i] = in_inst[i].rd;
      end
    end
    if (!fire) begin
      rs_d = '0;
      rob_d = '0;
    end
  end
  assign rob_tail_d = flush ? flush_rob_ptr : fire ? rob_tail_q + RW'(pre[WIDTH]) : rob_tail_q;
  assign rr_ptr_d = flush ? '0 : fire ? FW'((int'(rr_ptr_q) + int'(apre[WIDTH])) % NUM_ALU) : rr_ptr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rob_tail_q <= '0;
      rr_ptr_q <= '0;
      rs_q <= '0;
      rob_q <= '0;
    end else begin
      rob_tail_q <= rob_tail_d;
      rr_ptr_q <= rr_ptr_d;
      rs_q <= rs_d;
      rob_q <= rob_d;
    end
  end
  assign rs_line = rs_q;
  assign rob_dispatch = rob_q;
  dispatch_scoreboard u_sb (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .set_valid(cdb_valid),
    .set_preg(cdb_preg),
    .clr_valid(clr_valid),
    .clr_preg(clr_preg),
    .rdy(phy_reg_rdy)
  );
endmodule

// File: tb/tb_dispatch_nw.sv
// tb_dispatch_nw: directed self-checking bench for dispatch_nw
module tb_dispatch_nw;
  import dispatch_nw_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [WIDTH-1:0] in_valid;
  dispatchStruct [WIDTH-1:0] in_inst;
  logic in_ready;
  logic [SW-1:0] rs_free;
  logic [RW:0] rob_free;
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_CDB-1:0][PW-1:0] cdb_preg;
  logic flush;
  logic [RW-1:0] flush_rob_ptr;
  regReqStruct [2*WIDTH-1:0] reg_request;
  regRespStruct [2*WIDTH-1:0] reg_response;
  rsEntry [WIDTH-1:0] rs_line;
  robDispatchEntry [WIDTH-1:0] rob_dispatch;
  logic [NUM_PREGS-1:0] phy_reg_rdy;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  dispatch_nw dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .rs_free(rs_free), .rob_free(rob_free), .cdb_valid(cdb_valid), .cdb_preg(cdb_preg),
    .flush(flush), .flush_rob_ptr(flush_rob_ptr), .reg_request(reg_request),
    .reg_response(reg_response), .rs_line(rs_line), .rob_dispatch(rob_dispatch),
    .phy_reg_rdy(phy_reg_rdy)
  );
  function automatic dispatchStruct mk(bit rw, bit mem, bit asrc, int r1, int r2, int d);
    dispatchStruct s = '0;
    s.control.RegWrite = rw;
    s.control.MemRead = mem;
    s.control.MemtoReg = mem;
    s.control.ALUSrc = asrc;
    s.rs1 = PW'(r1);
    s.rs2 = PW'(r2);
    s.rd = PW'(d);
    s.imm = 32'(d * 16);
    return s;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = '0;
    in_inst = '0;
    cdb_valid = '0;
    cdb_preg = '0;
    flush = 1'b0;
    rob_free = 5'd16;
    rs_free = 4'd8;
    tick();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (rs_line !== '0) begin n_bad++; $display("FAIL reset_rs_line got %h exp 0", rs_line); end
    n_cmp++; if (rob_dispatch !== '0) begin n_bad++; $display("FAIL reset_rob got %h exp 0", rob_dispatch); end
    n_cmp++; if (phy_reg_rdy !== '1) begin n_bad++; $display("FAIL reset_rdy got %h exp all ones", phy_reg_rdy); end
    n_cmp++; if (reg_request !== '0) begin n_bad++; $display("FAIL reset_regreq got %h exp 0", reg_request); end
  endtask
  task automatic test_alu_pair();
    in_inst[0] = mk(1, 0, 0, 1, 2, 5);
    in_inst[1] = mk(1, 0, 0, 3, 4, 6);
    in_valid = 2'b11;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL alu_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (reg_request[0].addr !== 6'd1 || reg_request[3].addr !== 6'd4 || reg_request[3].RegWrite !== 1'b0) begin n_bad++; $display("FAIL alu_regreq got %0d/%0d/%b exp 1/4/0", reg_request[0].addr, reg_request[3].addr, reg_request[3].RegWrite); end
    tick();
    n_cmp++; if (rs_line[0].valid !== 1'b1 || rs_line[0].robNum !== 4'd0 || rs_line[0].fu !== 2'd0) begin n_bad++; $display("FAIL alu_lane0 got v%b rob%0d fu%0d exp v1 rob0 fu0", rs_line[0].valid, rs_line[0].robNum, rs_line[0].fu); end
    n_cmp++; if (rs_line[1].valid !== 1'b1 || rs_line[1].robNum !== 4'd1 || rs_line[1].fu !== 2'd1) begin n_bad++; $display("FAIL alu_lane1 got v%b rob%0d fu%0d exp v1 rob1 fu1", rs_line[1].valid, rs_line[1].robNum, rs_line[1].fu); end
    n_cmp++; if (rs_line[0].src1val !== 32'hA0 || rs_line[1].src2val !== 32'hA3) begin n_bad++; $display("FAIL alu_vals got %h/%h exp a0/a3", rs_line[0].src1val, rs_line[1].src2val); end
    n_cmp++; if (rob_dispatch[1].valid !== 1'b1 || rob_dispatch[1].robNum !== 4'd1 || rob_dispatch[1].rd !== 6'd6) begin n_bad++; $display("FAIL alu_rob1 got v%b rob%0d rd%0d exp v1 rob1 rd6", rob_dispatch[1].valid, rob_dispatch[1].robNum, rob_dispatch[1].rd); end
    n_cmp++; if (phy_reg_rdy[5] !== 1'b0 || phy_reg_rdy[6] !== 1'b0 || phy_reg_rdy[4] !== 1'b1) begin n_bad++; $display("FAIL alu_rdy got p5=%b p6=%b p4=%b exp 0 0 1", phy_reg_rdy[5], phy_reg_rdy[6], phy_reg_rdy[4]); end
    idle();
    n_cmp++; if (rs_line[0].valid !== 1'b0 || rob_dispatch[1].valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b/%b exp 0/0", rs_line[0].valid, rob_dispatch[1].valid); end
  endtask
  task automatic test_intra_dep();
    in_inst[0] = mk(1, 0, 0, 5, 0, 7);
    in_inst[1] = mk(1, 0, 1, 7, 6, 8);
    in_valid = 2'b11;
    tick();
    n_cmp++; if (rs_line[0].src1rdy !== 1'b0 || rs_line[0].src2rdy !== 1'b1) begin n_bad++; $display("FAIL dep_lane0 got %b/%b exp 0/1", rs_line[0].src1rdy, rs_line[0].src2rdy); end
    n_cmp++; if (rs_line[1].src1rdy !== 1'b0 || rs_line[1].src2rdy !== 1'b1) begin n_bad++; $display("FAIL dep_lane1 got %b/%b exp 0/1", rs_line[1].src1rdy, rs_line[1].src2rdy); end
    n_cmp++; if (rs_line[0].robNum !== 4'd2 || rs_line[1].robNum !== 4'd3) begin n_bad++; $display("FAIL dep_rob got %0d/%0d exp 2/3", rs_line[0].robNum, rs_line[1].robNum); end
    idle();
  endtask
  task automatic test_backpressure();
    in_inst[0] = mk(1, 1, 1, 0, 0, 10);
    in_inst[1] = mk(0, 0, 0, 1, 2, 0);
    in_valid = 2'b11;
    rs_free = 4'd1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_rsfree got %b exp 0", in_ready); end
    rs_free = 4'd8;
    rob_free = 5'd1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_robfree got %b exp 0", in_ready); end
    tick();
    n_cmp++; if (rs_line[0].valid !== 1'b0 || rs_line[1].valid !== 1'b0 || rob_dispatch[0].valid !== 1'b0) begin n_bad++; $display("FAIL bp_novalid got %b%b%b exp 000", rs_line[0].valid, rs_line[1].valid, rob_dispatch[0].valid); end
    n_cmp++; if (phy_reg_rdy[10] !== 1'b1) begin n_bad++; $display("FAIL bp_noclear got %b exp 1", phy_reg_rdy[10]); end
    rob_free = 5'd2;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept got %b exp 1", in_ready); end
    tick();
    n_cmp++; if (rs_line[0].robNum !== 4'd4 || rs_line[0].fu !== 2'd2) begin n_bad++; $display("FAIL bp_mem got rob%0d fu%0d exp rob4 fu2", rs_line[0].robNum, rs_line[0].fu); end
    n_cmp++; if (rs_line[1].robNum !== 4'd5 || rs_line[1].fu !== 2'd0) begin n_bad++; $display("FAIL bp_alu got rob%0d fu%0d exp rob5 fu0", rs_line[1].robNum, rs_line[1].fu); end
    idle();
  endtask
  task automatic test_back_to_back();
    in_inst[1] = mk(0, 0, 0, 3, 4, 0);
    in_valid = 2'b10;
    #1;
    n_cmp++; if (reg_request[0] !== '0 || reg_request[2].addr !== 6'd3) begin n_bad++; $display("FAIL single_regreq got %h/%0d exp 0/3", reg_request[0], reg_request[2].addr); end
    tick();
    n_cmp++; if (rs_line[0] !== '0 || rs_line[1].robNum !== 4'd6 || rs_line[1].fu !== 2'd1) begin n_bad++; $display("FAIL single_lane1 got l0=%h rob%0d fu%0d exp 0 rob6 fu1", rs_line[0], rs_line[1].robNum, rs_line[1].fu); end
    in_inst[0] = mk(0, 0, 0, 1, 1, 0);
    in_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (rs_line[0].robNum !== RW'(7 + 2*k) || rs_line[1].robNum !== RW'(8 + 2*k) || rs_line[0].fu !== 2'd0 || rs_line[1].fu !== 2'd1) begin n_bad++; $display("FAIL b2b_%0d got rob%0d/%0d fu%0d/%0d exp rob%0d/%0d fu0/1", k, rs_line[0].robNum, rs_line[1].robNum, rs_line[0].fu, rs_line[1].fu, (7+2*k)%16, (8+2*k)%16); end
    end
    in_valid = 2'b01;
    tick();
    n_cmp++; if (rs_line[0].robNum !== 4'd1 || rs_line[0].fu !== 2'd0 || rs_line[1].valid !== 1'b0) begin n_bad++; $display("FAIL wrap_tail got rob%0d fu%0d v1=%b exp rob1 fu0 v0", rs_line[0].robNum, rs_line[0].fu, rs_line[1].valid); end
    idle();
  endtask
  task automatic test_cdb();
    in_inst[0] = mk(1, 0, 0, 0, 0, 12);
    in_valid = 2'b01;
    tick();
    n_cmp++; if (rs_line[0].robNum !== 4'd2 || rs_line[0].fu !== 2'd1 || phy_reg_rdy[12] !== 1'b0) begin n_bad++; $display("FAIL cdb_prep got rob%0d fu%0d p12=%b exp rob2 fu1 0", rs_line[0].robNum, rs_line[0].fu, phy_reg_rdy[12]); end
    in_inst[0] = mk(1, 0, 0, 0, 0, 9);
    in_inst[1] = mk(0, 0, 0, 12, 8, 0);
    in_valid = 2'b11;
    cdb_valid = 2'b11;
    cdb_preg[0] = 6'd9;
    cdb_preg[1] = 6'd12;
    tick();
    n_cmp++; if (rs_line[1].src1rdy !== 1'b1 || rs_line[1].src2rdy !== 1'b0) begin n_bad++; $display("FAIL cdb_wake got %b/%b exp 1/0", rs_line[1].src1rdy, rs_line[1].src2rdy); end
    n_cmp++; if (phy_reg_rdy[9] !== 1'b0 || phy_reg_rdy[12] !== 1'b1) begin n_bad++; $display("FAIL cdb_sb got p9=%b p12=%b exp 0 1", phy_reg_rdy[9], phy_reg_rdy[12]); end
    n_cmp++; if (rs_line[0].robNum !== 4'd3 || rs_line[1].robNum !== 4'd4) begin n_bad++; $display("FAIL cdb_rob got %0d/%0d exp 3/4", rs_line[0].robNum, rs_line[1].robNum); end
    idle();
  endtask
  task automatic test_flush();
    in_inst[0] = mk(0, 0, 0, 1, 1, 0);
    in_valid = 2'b01;
    tick();
    n_cmp++; if (rs_line[0].robNum !== 4'd5 || rs_line[0].fu !== 2'd0) begin n_bad++; $display("FAIL flush_pre got rob%0d fu%0d exp rob5 fu0", rs_line[0].robNum, rs_line[0].fu); end
    in_inst[0] = mk(1, 0, 0, 1, 1, 20);
    in_inst[1] = mk(1, 0, 0, 1, 1, 21);
    in_valid = 2'b11;
    flush = 1'b1;
    flush_rob_ptr = 4'd4;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    tick();
    n_cmp++; if (rs_line[0].valid !== 1'b0 || rs_line[1].valid !== 1'b0 || rob_dispatch[0].valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b%b%b exp 000", rs_line[0].valid, rs_line[1].valid, rob_dispatch[0].valid); end
    n_cmp++; if (phy_reg_rdy !== '1) begin n_bad++; $display("FAIL flush_rdy got %h exp all ones", phy_reg_rdy); end
    flush = 1'b0;
    in_inst[0] = mk(0, 0, 0, 1, 1, 0);
    in_inst[1] = mk(0, 0, 0, 1, 1, 0);
    tick();
    n_cmp++; if (rs_line[0].robNum !== 4'd4 || rs_line[1].robNum !== 4'd5 || rs_line[0].fu !== 2'd0 || rs_line[1].fu !== 2'd1) begin n_bad++; $display("FAIL flush_after got rob%0d/%0d fu%0d/%0d exp 4/5 0/1", rs_line[0].robNum, rs_line[1].robNum, rs_line[0].fu, rs_line[1].fu); end
    idle();
  endtask
  initial begin
    reset = 1'b1;
    in_valid = '0;
    in_inst = '0;
    rs_free = 4'd8;
    rob_free = 5'd16;
    cdb_valid = '0;
    cdb_preg = '0;
    flush = 1'b0;
    flush_rob_ptr = '0;
    for (int k = 0; k < 2*WIDTH; k++) reg_response[k].data = 32'hA0 + 32'(k);
    test_reset();
    test_alu_pair();
    test_intra_dep();
    test_backpressure();
    test_back_to_back();
    test_cdb();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dispatch_nw.md
Name: dispatch_nw

Overview:
Parametrised N-wide dispatch stage that sits between the rename/dispatch register and the reservation station (RS) and reorder buffer (ROB).
- Allocates ROB numbers with wrap-around.
- Tracks physical-register readiness with CDB wakeup.
- Resolves intra-group dependencies.
- Assigns functional units (FUs) round-robin.
- Applies all-or-nothing backpressure from RS/ROB free counts.
- Registers the RS and ROB write outputs: one cycle of latency.

Parameters:
WIDTH, 2, instructions dispatched per cycle (lanes)
ROB_DEPTH, 16, ROB entries; power of two; ROB number width RW = clog2(ROB_DEPTH)
NUM_PREGS, 64, physical registers; preg 0 is hard-wired ready
NUM_ALU, 2, ALU FUs, ids 0..NUM_ALU-1; memory FU id = NUM_ALU
NUM_CDB, 2, completion/wakeup broadcast ports

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  WIDTH  per-lane instruction valid
in_inst  in  WIDTH x dispatchStruct  per-lane decoded/renamed instruction
in_ready  out  1  group accepted this cycle (combinational)
rs_free  in  clog2(RS size)+1  free RS entries
rob_free  in  RW+1  free ROB entries
cdb_valid  in  NUM_CDB  completion broadcast valid
cdb_preg  in  NUM_CDB x clog2(NUM_PREGS)  completing physical register
flush  in  1  squash all in-flight state
flush_rob_ptr  in  RW  ROB tail to restore on flush
reg_request  out  2*WIDTH x regReqStruct  regfile read requests (combinational)
reg_response  in  2*WIDTH x regRespStruct  regfile read data (combinational)
rs_line  out  WIDTH x rsEntry  registered RS write lines
rob_dispatch  out  WIDTH x robDispatchEntry  registered ROB allocation lines
phy_reg_rdy  out  NUM_PREGS  ready scoreboard

Behaviour:
- Reset:
  - rob_tail=0, rr_ptr=0, phy_reg_rdy all 1.
  - All rs_line and rob_dispatch fields 0, including valid.
- Lane count:
  - n = popcount(in_valid).
  - fire = (n != 0) && rob_free >= n && rs_free >= n && !flush.
  - in_ready = fire, or n == 0 && !flush.
  - Partial groups are never accepted; with no fire, nothing advances.
- ROB numbering:
  - Lane i gets rob_tail + (number of valid lanes below i), mod ROB_DEPTH.
  - On fire, rob_tail += n, wrapping modulo ROB_DEPTH.
- Outputs:
  - Registered; valid in cycle t+1 for a fire in cycle t.
  - With no fire, all valid bits are 0 next cycle.
  - Invalid lanes drive all-zero lines.
- Register reads:
  - reg_request[2i] carries lane i rs1; reg_request[2i+1] carries lane i rs2.
  - RegWrite=0 always; fields are zero when the lane is invalid.
  - Responses are captured into src1val/src2val.
- Source ready for lane i:
  - Ready = phy_reg_rdy[rs] OR any same-cycle cdb hit on rs OR rs == 0.
  - Forced 0 if any valid lane j < i has RegWrite && rd == rs && rd != 0.
  - src2rdy is forced 1 when control.ALUSrc is set.
- Scoreboard update, per cycle:
  - Each cdb_valid sets its preg.
  - Each fired lane with RegWrite && rd != 0 clears its rd (MemWrite lanes never clear).
  - Same preg set and cleared in the same cycle: clear wins.
  - Bit 0 always reads 1.
- FU assignment:
  - Memory op (MemRead | MemWrite | MemtoReg) gets fu = NUM_ALU.
  - ALU ops take rr_ptr, rr_ptr+1, ... in lane order, mod NUM_ALU.
  - On fire, rr_ptr advances by the number of ALU ops, mod NUM_ALU.
- Flush (priority over fire):
  - rob_tail <= flush_rob_ptr; rr_ptr <= 0; phy_reg_rdy <= all 1.
  - Output valids 0 next cycle; in_ready = 0.
- Reset mid-operation overrides flush and fire.

Decomposition:
- typedefs package additions: robDispatchEntry, plus localparams for FU id encoding, RW and preg index width; regReqStruct/regRespStruct reused unchanged.
- Sub-module dispatch_scoreboard holds phy_reg_rdy, with set/clear ports and the priority rule.
- Lane-prefix counting and FU round-robin stay in the top module as generate loops.

Test Plan:
1. Reset, then 2 ALU ops (rd=5, rd=6), rob_free=16, rs_free=8 -> next cycle robNum 0/1, fu 0/1; phy_reg_rdy[5]=phy_reg_rdy[6]=0; rob_tail=2.
2. Lane 0 writes p7, lane 1 reads rs1=p7 with p7 ready -> lane 1 src1rdy=0; lane 0 src1rdy taken from scoreboard.
3. rob_free=1 with both lanes valid -> in_ready=0; no output valid; rob_tail and rr_ptr unchanged; raise rob_free=2 -> accepted.
4. rob_tail=15, 2 lanes fire -> robNum 15 and 0; rob_tail=1.
5. Same cycle: cdb sets p9 and lane 0 dispatches rd=p9 -> phy_reg_rdy[9]=0. Lane 1 reading p12 with a cdb hit on p12 -> src1rdy=1.
6. flush with flush_rob_ptr=4 while lanes are valid -> no outputs; rob_tail=4; phy_reg_rdy all 1; rr_ptr=0.
